// File: rtl/cam_init_seq.sv
// cam_init_seq: walks a {reg,val} table in an external ROM and streams camera
// register writes (device address, register, value) into an I2C command FIFO.
// Table entries may also request a delay or mark the end of the table.
module cam_init_seq #(
    parameter logic [7:0] DEV_ADDR   = 8'h42,
    parameter int         DELAY_UNIT = 24000,
    parameter int         GAP_WAIT   = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  ROM_ADDR,
    input  logic [15:0] ROM_DATA,
    output logic        FIFO_WE,
    output logic [8:0]  FIFO_WData,
    input  logic        FIFO_Full,
    input  logic        FIFO_Empty
);

    // Counter must hold the longest delay (255 units) and never be narrower than 24 bits.
    localparam int DLY_MAX = 255 * DELAY_UNIT;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int GAP_W   = $clog2(GAP_WAIT + 1);
    localparam int CNT_W0  = (DLY_W > 24) ? DLY_W : 24;
    localparam int CNT_W   = (GAP_W > CNT_W0) ? GAP_W : CNT_W0;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        PUSH_DEV,
        PUSH_REG,
        PUSH_VAL,
        DRAIN,
        GAP,
        DELAY,
        NEXT,
        FINISH
    } state_t;

    state_t           state;
    logic [7:0]       reg_byte;
    logic [7:0]       val_byte;
    logic [CNT_W-1:0] cnt;
    logic             push_st;

    // The write strobe has to react to FIFO_Full in the same cycle, so it is
    // decoded from the registered state rather than registered itself.
    assign push_st = (state == PUSH_DEV) || (state == PUSH_REG) || (state == PUSH_VAL);
    assign FIFO_WE = push_st && !FIFO_Full;

    // Sequencer: table walk, FIFO pushes, drain/gap and delay timing.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ROM_ADDR   <= '0;
            FIFO_WData <= '0;
            cnt        <= '0;
            reg_byte   <= '0;
            val_byte   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        ROM_ADDR <= '0;
                        DONE     <= 1'b0;
                        BUSY     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                // ROM output lags the address by one cycle.
                FETCH: state <= DECODE;
                DECODE: begin
                    if (ROM_DATA == 16'hFFFF) begin
                        state <= FINISH;
                    end else if (ROM_DATA[15:8] == 8'hFF) begin
                        cnt   <= CNT_W'(ROM_DATA[7:0]) * CNT_W'(DELAY_UNIT);
                        state <= DELAY;
                    end else if (ROM_DATA[7:0] == 8'h00) begin
                        state <= NEXT;
                    end else begin
                        reg_byte   <= ROM_DATA[15:8];
                        val_byte   <= ROM_DATA[7:0];
                        // First word is staged now so the pushes run back to back.
                        FIFO_WData <= {DEV_ADDR, 1'b0};
                        state      <= PUSH_DEV;
                    end
                end
                PUSH_DEV: begin
                    if (!FIFO_Full) begin
                        FIFO_WData <= {reg_byte, 1'b0};
                        state      <= PUSH_REG;
                    end
                end
                PUSH_REG: begin
                    if (!FIFO_Full) begin
                        FIFO_WData <= {val_byte, 1'b0};
                        state      <= PUSH_VAL;
                    end
                end
                PUSH_VAL: begin
                    if (!FIFO_Full) state <= DRAIN;
                end
                // The I2C stage issues STOP once the FIFO runs dry.
                DRAIN: begin
                    if (FIFO_Empty) begin
                        cnt   <= CNT_W'(GAP_WAIT - 1);
                        state <= GAP;
                    end
                end
                // Spend GAP_WAIT cycles here so the STOP completes.
                GAP: begin
                    if (cnt == '0) state <= NEXT;
                    else           cnt   <= cnt - 1'b1;
                end
                DELAY: begin
                    if (cnt == '0) state <= NEXT;
                    else           cnt   <= cnt - 1'b1;
                end
                // The last table slot ends the run instead of wrapping the address.
                NEXT: begin
                    if (ROM_ADDR == 8'hFF) begin
                        state <= FINISH;
                    end else begin
                        ROM_ADDR <= ROM_ADDR + 8'd1;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_init_seq.sv
// tb_cam_init_seq: drives cam_init_seq with a behavioural ROM and I2C FIFO,
// and compares the words written and the run timing against a table-level model.
module tb_cam_init_seq;

    localparam int         DU  = 10;
    localparam int         GW  = 8;
    localparam logic [7:0] DEV = 8'h42;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        BUSY, DONE;
    logic [7:0]  ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic        FIFO_WE;
    logic [8:0]  FIFO_WData;
    logic        FIFO_Full, FIFO_Empty;

    logic [15:0] rom [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          fifo_cnt = 0;
    bit          full_force = 0, full_rand = 0, rand_full_en = 0;
    bit          pop_rand = 1, rand_pop_en = 0;
    logic        pop_ok;

    logic [8:0]  wq[$];
    int          wcyc[$];
    logic [8:0]  exp_q[$];
    int          exp_lat;
    bit          lat_known;
    logic [7:0]  exp_addr;

    cam_init_seq #(.DEV_ADDR(DEV), .DELAY_UNIT(DU), .GAP_WAIT(GW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .FIFO_WE(FIFO_WE),
        .FIFO_WData(FIFO_WData), .FIFO_Full(FIFO_Full), .FIFO_Empty(FIFO_Empty)
    );

    always #5 CLK = ~CLK;

    // Synchronous ROM: data follows the address one cycle later.
    always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

    assign pop_ok     = !rand_pop_en || pop_rand;
    assign FIFO_Full  = full_force | full_rand | (fifo_cnt >= 8);
    assign FIFO_Empty = (fifo_cnt == 0);

    // FIFO occupancy: the I2C side pops at most one word per cycle.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) fifo_cnt <= 0;
        else     fifo_cnt <= fifo_cnt + ((FIFO_WE === 1'b1) ? 1 : 0)
                             - ((pop_ok && fifo_cnt > 0) ? 1 : 0);
    end

    always @(posedge CLK) begin
        #1;
        full_rand = rand_full_en && ($urandom_range(3) == 0);
        pop_rand  = ($urandom_range(2) != 0);
    end

    // Capture every written word mid-cycle; a write into a full FIFO is an error.
    always @(negedge CLK) begin
        if (FIFO_WE === 1'b1) begin
            wq.push_back(FIFO_WData);
            wcyc.push_back(cyc);
            checks++;
            if (FIFO_Full !== 1'b0) begin
                errors++;
                $display("FAIL we_while_full: FIFO_WE=1 with FIFO_Full=%b at cycle %0d", FIFO_Full, cyc);
            end
        end
    end

    // Table-level model: words produced and cycles from accepted START to DONE
    // (timing only known for tables without register writes).
    task automatic model_run();
        logic [15:0] e;
        exp_q.delete();
        exp_lat   = 0;
        lat_known = 1;
        exp_addr  = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            e = rom[i];
            if (e == 16'hFFFF) begin
                exp_addr = 8'(i);
                exp_lat += 3;
                return;
            end
            if (e[15:8] == 8'hFF) begin
                exp_lat += 4 + int'(e[7:0]) * DU;
            end else if (e[7:0] == 8'h00) begin
                exp_lat += 3;
            end else begin
                exp_q.push_back({DEV, 1'b0});
                exp_q.push_back({e[15:8], 1'b0});
                exp_q.push_back({e[7:0], 1'b0});
                lat_known = 0;
            end
        end
        exp_lat += 1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic clear_cap();
        wq.delete();
        wcyc.delete();
    endtask

    task automatic start_pulse();
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
    endtask

    task automatic wait_done(input int bound, input bit extra, output int n, output bit ok);
        n  = 0;
        ok = 0;
        while (n < bound) begin
            @(posedge CLK); #1;
            START = 1'b0;
            n++;
            if (DONE === 1'b1) begin
                ok = 1;
                break;
            end
            if (extra && BUSY === 1'b1 && $urandom_range(19) == 0) START = 1'b1;
        end
        START = 1'b0;
    endtask

    task automatic compare_words(input string tag);
        checks++;
        if (wq.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d words want %0d", tag, wq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (wq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_word%0d: got %h want %h", tag, i, wq[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", DONE); end
        checks++; if (FIFO_WE !== 1'b0)    begin errors++; $display("FAIL rst_we: got %b want 0", FIFO_WE); end
        checks++; if (FIFO_WData !== 9'h0) begin errors++; $display("FAIL rst_wdata: got %h want 000", FIFO_WData); end
        checks++; if (ROM_ADDR !== 8'h00)  begin errors++; $display("FAIL rst_addr: got %h want 00", ROM_ADDR); end
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL idle_hold: busy %b done %b want 0 0", BUSY, DONE); end
    endtask

    task automatic test_basic();
        int n; bit ok;
        clear_rom();
        rom[0] = 16'h1280;
        clear_cap();
        start_pulse();
        checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin errors++; $display("FAIL basic_busy: busy %b done %b want 1 0", BUSY, DONE); end
        wait_done(500, 0, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: DONE not seen in %0d cycles", n); end
        exp_q.delete();
        exp_q.push_back(9'h084); exp_q.push_back(9'h024); exp_q.push_back(9'h100);
        compare_words("basic");
        if (wcyc.size() == 3) begin
            checks++;
            if (wcyc[1] != wcyc[0] + 1 || wcyc[2] != wcyc[1] + 1) begin
                errors++; $display("FAIL basic_consec: write cycles %0d %0d %0d want consecutive", wcyc[0], wcyc[1], wcyc[2]);
            end
        end
        // FETCH+DECODE+3 pushes+2 drain (last word leaves one cycle into DRAIN,
        // Empty seen the cycle after)+GW+NEXT, then the end marker: FETCH+DECODE+FINISH.
        checks++; if (n != 2 + 3 + 2 + GW + 1 + 3) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n, 2 + 3 + 2 + GW + 1 + 3); end
        checks++; if (ROM_ADDR !== 8'h01) begin errors++; $display("FAIL basic_addr: got %h want 01", ROM_ADDR); end
        checks++; if (BUSY !== 1'b0 || fifo_cnt != 0) begin errors++; $display("FAIL basic_end: busy %b fifo %0d want 0 0", BUSY, fifo_cnt); end
    endtask

    task automatic test_full_stall();
        int n; bit ok; bit seen;
        clear_rom();
        rom[0] = 16'h1280;
        clear_cap();
        start_pulse();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge CLK); #1;
            if (FIFO_WE === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL stall_no_push: FIFO_WE got 0 want 1 within 20 cycles");
        end else begin
            @(posedge CLK); #1 full_force = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge CLK);
                checks++; if (FIFO_WE !== 1'b0) begin errors++; $display("FAIL stall_we%0d: got %b want 0", i, FIFO_WE); end
            end
            @(posedge CLK); #1 full_force = 1'b0;
        end
        wait_done(500, 0, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: DONE not seen in %0d cycles", n); end
        exp_q.delete();
        exp_q.push_back(9'h084); exp_q.push_back(9'h024); exp_q.push_back(9'h100);
        compare_words("stall");
        if (wcyc.size() == 3) begin
            checks++;
            if (wcyc[1] != wcyc[0] + 6 || wcyc[2] != wcyc[1] + 1) begin
                errors++; $display("FAIL stall_cycles: gaps %0d %0d want 6 1", wcyc[1] - wcyc[0], wcyc[2] - wcyc[1]);
            end
        end
    endtask

    task automatic test_delay();
        int n; bit ok;
        clear_rom();
        rom[0] = 16'hFF02;
        model_run();
        clear_cap();
        start_pulse();
        wait_done(500, 0, n, ok);
        checks++; if (!ok || n != exp_lat) begin errors++; $display("FAIL delay_latency: got %0d (done %b) want %0d", n, ok, exp_lat); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL delay_writes: got %0d words want 0", wq.size()); end
        checks++; if (ROM_ADDR !== exp_addr) begin errors++; $display("FAIL delay_addr: got %h want %h", ROM_ADDR, exp_addr); end
    endtask

    task automatic test_no_marker();
        int n; bit ok;
        for (int i = 0; i < 256; i++) rom[i] = {8'($urandom_range(254)), 8'h00};
        model_run();
        clear_cap();
        start_pulse();
        wait_done(2000, 0, n, ok);
        checks++; if (!ok || n != exp_lat) begin errors++; $display("FAIL nomark_latency: got %0d (done %b) want %0d", n, ok, exp_lat); end
        checks++; if (ROM_ADDR !== 8'hFF) begin errors++; $display("FAIL nomark_addr: got %h want ff", ROM_ADDR); end
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL nomark_writes: got %0d words want 0", wq.size()); end
    endtask

    task automatic test_reset_mid_delay();
        int n; bit ok;
        clear_rom();
        rom[0] = 16'hFF05;
        rom[1] = 16'h3311;
        model_run();
        start_pulse();
        repeat (20) @(posedge CLK);
        clear_cap();
        #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || FIFO_WE !== 1'b0 || FIFO_WData !== 9'h0 || ROM_ADDR !== 8'h00) begin
            errors++; $display("FAIL rstdly_outputs: busy %b done %b we %b wdata %h addr %h want all 0", BUSY, DONE, FIFO_WE, FIFO_WData, ROM_ADDR);
        end
        repeat (100) @(posedge CLK);
        #1;
        checks++; if (wq.size() != 0 || BUSY !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL rstdly_dead: words %0d busy %b done %b want 0 0 0", wq.size(), BUSY, DONE); end
        start_pulse();
        wait_done(1000, 0, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstdly_rerun: DONE not seen in %0d cycles", n); end
        compare_words("rstdly");
        checks++; if (ROM_ADDR !== exp_addr) begin errors++; $display("FAIL rstdly_addr: got %h want %h", ROM_ADDR, exp_addr); end
    endtask

    task automatic test_reset_mid_push();
        clear_rom();
        rom[0] = 16'h1280;
        full_force = 1'b1;
        start_pulse();
        repeat (10) @(posedge CLK);
        clear_cap();
        #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        full_force = 1'b0;
        repeat (30) @(posedge CLK);
        #1;
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL rstpush_writes: got %0d words want 0", wq.size()); end
        checks++; if (FIFO_WData !== 9'h0 || BUSY !== 1'b0) begin errors++; $display("FAIL rstpush_state: wdata %h busy %b want 000 0", FIFO_WData, BUSY); end
    endtask

    task automatic test_random();
        int n; bit ok; int len;
        rand_full_en = 1;
        rand_pop_en  = 1;
        for (int it = 0; it < 8; it++) begin
            clear_rom();
            len = $urandom_range(12, 1);
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(3))
                    0: rom[i] = {8'($urandom_range(254)), 8'h00};
                    1: rom[i] = {8'hFF, 8'($urandom_range(3, 1))};
                    default: rom[i] = {8'($urandom_range(254)), 8'($urandom_range(255, 1))};
                endcase
            end
            model_run();
            clear_cap();
            start_pulse();
            checks++; if (DONE !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL rnd%0d_start: done %b busy %b want 0 1", it, DONE, BUSY); end
            wait_done(5000, 1, n, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_timeout: DONE not seen in %0d cycles", it, n); end
            compare_words($sformatf("rnd%0d", it));
            checks++; if (ROM_ADDR !== exp_addr) begin errors++; $display("FAIL rnd%0d_addr: got %h want %h", it, ROM_ADDR, exp_addr); end
            if (lat_known) begin
                checks++; if (n != exp_lat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, n, exp_lat); end
            end
        end
        rand_full_en = 0;
        rand_pop_en  = 0;
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_basic();
        test_full_stall();
        test_delay();
        test_no_marker();
        test_reset_mid_delay();
        test_reset_mid_push();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
